// File: rtl/mc_core_pkg.sv
// Shared opcodes, immediate-format codes, FSM states and decode bundle for the multi-cycle core control path.
package mc_core_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [3:0] OP_ALU   = 4'd0;
    localparam logic [3:0] OP_ALUI  = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] OP_BNE   = 4'd5;
    localparam logic [3:0] OP_JAL   = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd7;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_J = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_MEM_WAIT,
        S_WB,
        S_HALT
    } state_t;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] imm_src;
        logic       result_src;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_halt;
        logic       is_illegal;
    } dec_t;

endpackage

// File: rtl/mc_core_decode.sv
// Combinational opcode decoder: datapath selects plus instruction-class flags for the control FSM.
module mc_core_decode
    import mc_core_pkg::*;
#(
    parameter int unsigned OPC_W = 4
) (
    input  logic [OPC_W-1:0] i_opcode,
    output dec_t             o_dec
);

    always_comb begin
        o_dec = '0;
        case (i_opcode)
            OPC_W'(OP_ALU): begin
                o_dec.imm_src = IMM_I;
            end
            OPC_W'(OP_ALUI): begin
                o_dec.alu_src = 1'b1;
                o_dec.imm_src = IMM_I;
            end
            OPC_W'(OP_LOAD): begin
                o_dec.alu_src    = 1'b1;
                o_dec.imm_src    = IMM_I;
                o_dec.result_src = 1'b1;
                o_dec.is_load    = 1'b1;
            end
            OPC_W'(OP_STORE): begin
                o_dec.alu_src  = 1'b1;
                o_dec.imm_src  = IMM_S;
                o_dec.is_store = 1'b1;
            end
            OPC_W'(OP_BEQ), OPC_W'(OP_BNE): begin
                o_dec.imm_src   = IMM_B;
                o_dec.is_branch = 1'b1;
            end
            OPC_W'(OP_JAL): begin
                o_dec.imm_src = IMM_J;
                o_dec.is_jal  = 1'b1;
            end
            OPC_W'(OP_HALT): begin
                o_dec.is_halt = 1'b1;
            end
            default: begin
                o_dec.is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mc_core_ctrl.sv
// Multi-cycle control FSM: owns the PC, IR and the shared instruction/data memory port.
// Optional MC_CORE_PERF_CNT_EN adds cycle_cnt/instret_cnt performance counters.
module mc_core_ctrl
    import mc_core_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     OPC_W    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_we,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    input  logic [XLEN-1:0] alu_result,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc,
    output logic [ILEN-1:0] ir,
    output logic            reg_write,
    output logic            alu_src,
    output logic [1:0]      imm_src,
    output logic            result_src,
    output logic            halted,
`ifdef MC_CORE_PERF_CNT_EN
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt,
`endif
    output logic            illegal
);

    localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(INSTR_BYTES - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_mem_addr;
    logic [ILEN-1:0] r_ir;
    logic            r_reg_write;
    logic            r_alu_src;
    logic [1:0]      r_imm_src;
    logic            r_result_src;
    logic            r_halted;
    logic            r_illegal;
    logic [OPC_W-1:0] w_opcode;
    logic [XLEN-1:0] w_pc_seq;
    dec_t            w_dec;

    // Decode the incoming word while waiting for it so the selects are already registered in DECODE.
    assign w_opcode = (r_state == S_FETCH_WAIT) ? mem_rsp_data[OPC_W-1:0] : r_ir[OPC_W-1:0];
    assign w_pc_seq = (r_pc + XLEN'(INSTR_BYTES)) & PC_MASK;

    mc_core_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .i_opcode (w_opcode),
        .o_dec    (w_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_req_ready) w_next_state = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                if (mem_rsp_valid) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                if (w_dec.is_illegal || w_dec.is_halt) begin
                    w_next_state = S_HALT;
                end else if (w_dec.is_load || w_dec.is_store) begin
                    w_next_state = S_MEM;
                end else if (w_dec.is_branch) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                if (mem_req_ready) w_next_state = w_dec.is_load ? S_MEM_WAIT : S_FETCH;
            end
            S_MEM_WAIT: begin
                if (mem_rsp_valid) w_next_state = S_WB;
            end
            S_WB: begin
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC & PC_MASK;
            r_ir         <= '0;
            r_mem_addr   <= '0;
            r_reg_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_imm_src    <= '0;
            r_result_src <= 1'b0;
            r_halted     <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_reg_write <= (w_next_state == S_WB);
            if (w_next_state == S_HALT) r_halted <= 1'b1;

            case (r_state)
                S_FETCH_WAIT: begin
                    if (mem_rsp_valid) r_ir <= mem_rsp_data;
                end
                S_EXEC: begin
                    // Latch the effective address so it stays stable across a stalled MEM request.
                    r_mem_addr <= alu_result;
                    if (w_dec.is_branch) r_pc <= branch_taken ? (branch_target & PC_MASK) : w_pc_seq;
                    if (w_dec.is_jal) r_pc <= branch_target & PC_MASK;
                    if (w_dec.is_illegal) r_illegal <= 1'b1;
                end
                S_MEM: begin
                    if (mem_req_ready && w_dec.is_store) r_pc <= w_pc_seq;
                end
                S_WB: begin
                    if (!w_dec.is_jal) r_pc <= w_pc_seq;
                end
                default: begin
                end
            endcase

            if (r_state == S_FETCH_WAIT && mem_rsp_valid) begin
                r_alu_src    <= w_dec.alu_src;
                r_imm_src    <= w_dec.imm_src;
                r_result_src <= w_dec.result_src;
            end else if (w_next_state == S_FETCH || w_next_state == S_HALT) begin
                r_alu_src    <= 1'b0;
                r_imm_src    <= '0;
                r_result_src <= 1'b0;
            end
        end
    end

    assign mem_req_valid = (r_state == S_FETCH) || (r_state == S_MEM);
    assign mem_req_we    = (r_state == S_MEM) && w_dec.is_store;
    assign mem_req_addr  = (r_state == S_MEM) ? r_mem_addr : r_pc;

    assign pc         = r_pc;
    assign ir         = r_ir;
    assign reg_write  = r_reg_write;
    assign alu_src    = r_alu_src;
    assign imm_src    = r_imm_src;
    assign result_src = r_result_src;
    assign halted     = r_halted;
    assign illegal    = r_illegal;

`ifdef MC_CORE_PERF_CNT_EN
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret_cnt;
    logic        w_retire;

    assign w_retire = (r_state == S_WB)
                   || (r_state == S_MEM && mem_req_ready && w_dec.is_store)
                   || (r_state == S_EXEC && w_dec.is_branch);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 64'd1;
            if (w_retire) r_instret_cnt <= r_instret_cnt + 64'd1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    // Counters are absent in this build.
`endif

endmodule
